ascon_aead: RTL and testbench



---
 rtl/ascon_aead.sv | 198 +++++++++++++++++++
 tb/tb_ascon_aead.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead.sv
`default_nettype none
// ============================================================================
// Module   : ascon_aead
// Purpose  : ASCON-128 (v1.2) authenticated encryption/decryption core.
//            One permutation round per clock, fixed-schedule absorption of
//            64-bit associated-data and text blocks, 128-bit tag output.
// Revision : 1.0  initial release
// ============================================================================
module ascon_aead (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         startAD,
  input  logic         startT,
  input  logic         enc,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [63:0]  ADblock,
  input  logic [63:0]  PTblock,
  input  logic [3:0]   PTlen,
  input  logic [3:0]   ADlen,
  output logic [127:0] T,
  output logic [63:0]  CTblock,
  output logic         CTv,
  output logic         Tv,
  output logic         read
);

  localparam logic [63:0] C_IV = 64'h80400c0600000000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_AD    = 3'd2,
    S_TEXT  = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_first;    // next edge is the decision edge after init
  logic         r_ad_last;  // AD block currently in its rounds was padded
  logic [63:0]  r_x0, r_x1, r_x2, r_x3, r_x4;
  logic [127:0] r_key;
  logic [127:0] r_tag;
  logic         r_tv;

  logic [3:0]   w_ptl, w_adl, w_tl, w_ridx;
  logic         w_dec, w_ad_abs, w_tx_abs, w_full, w_fin_abs;
  logic [319:0] w_s, w_r;

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One ASCON round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    a0 = s[319:256];
    a1 = s[255:192];
    a2 = s[191:128] ^ {56'd0, ~r, r};
    a3 = s[127:64];
    a4 = s[63:0];
    a0 = a0 ^ a4;  a4 = a4 ^ a3;  a2 = a2 ^ a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 = a0 ^ t1;  a1 = a1 ^ t2;  a2 = a2 ^ t3;  a3 = a3 ^ t4;  a4 = a4 ^ t0;
    a1 = a1 ^ a0;  a0 = a0 ^ a4;  a3 = a3 ^ a2;  a2 = ~a2;
    a0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
    a1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
    a2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
    a3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
    a4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
    return {a0, a1, a2, a3, a4};
  endfunction

  // Mask keeping bytes 0..len-1 (byte 0 in the top bits); len 8 keeps all.
  function automatic logic [63:0] keep_mask(input logic [3:0] len);
    return ~(64'hFFFF_FFFF_FFFF_FFFF >> {len, 3'b000});
  endfunction

  // 0x80 marker at byte len; nothing when the block is full.
  function automatic logic [63:0] pad_bit(input logic [3:0] len);
    return 64'h8000_0000_0000_0000 >> {len, 3'b000};
  endfunction

  assign w_ptl = PTlen[3] ? 4'd8 : PTlen;
  assign w_adl = ADlen[3] ? 4'd8 : ADlen;
  assign w_tl  = startT ? w_ptl : 4'd0;

  assign w_dec     = (r_state == S_AD) && r_first;
  assign w_ad_abs  = (r_state == S_AD) && (r_cnt == 4'd0) && (!r_first || startAD);
  assign w_tx_abs  = ((r_state == S_TEXT) && (r_cnt == 4'd0)) || (w_dec && !startAD);
  assign w_full    = w_tx_abs && startT && (w_ptl == 4'd8);
  assign w_fin_abs = w_tx_abs && !w_full;

  // Build the state that enters this cycle's round (block absorption, key mixing).
  always_comb begin
    w_s    = {r_x0, r_x1, r_x2, r_x3, r_x4};
    w_ridx = ((r_state == S_AD) || (r_state == S_TEXT)) ? (r_cnt + 4'd6) : r_cnt;
    if ((r_state == S_INIT) && (r_cnt == 4'd0))
      w_s = {C_IV, key, nonce};
    if (w_dec && !startAD)
      w_s[63:0] = w_s[63:0] ^ 64'd1;
    if (w_ad_abs)
      w_s[319:256] = w_s[319:256] ^ (ADblock & keep_mask(w_adl)) ^ pad_bit(w_adl);
    if (w_full)
      w_s[319:256] = enc ? (r_x0 ^ PTblock) : PTblock;
    if (w_fin_abs) begin
      w_s[319:256] = (enc ? (r_x0 ^ (PTblock & keep_mask(w_tl)))
                          : ((PTblock & keep_mask(w_tl)) | (r_x0 & ~keep_mask(w_tl))))
                     ^ pad_bit(w_tl);
      w_s[255:128] = w_s[255:128] ^ r_key;
      w_ridx       = 4'd0;
    end
  end

  assign w_r = ascon_round(w_s, w_ridx);

  assign CTv     = w_tx_abs && startT;
  assign CTblock = CTv ? (r_x0 ^ PTblock) : 64'd0;
  assign read    = w_ad_abs || w_tx_abs;
  assign T       = r_tag;
  assign Tv      = r_tv;

  // Phase sequencing, round counting and permutation state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_first   <= 1'b0;
      r_ad_last <= 1'b0;
      {r_x0, r_x1, r_x2, r_x3, r_x4} <= 320'd0;
      r_key     <= 128'd0;
      r_tag     <= 128'd0;
      r_tv      <= 1'b0;
    end else if (start) begin
      r_state <= S_INIT;
      r_cnt   <= 4'd0;
      r_first <= 1'b0;
      r_tag   <= 128'd0;
      r_tv    <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          {r_x0, r_x1, r_x2, r_x3, r_x4} <= w_r;
          if (r_cnt == 4'd0)
            r_key <= key;
          if (r_cnt == 4'd11) begin
            r_x3    <= w_r[127:64] ^ r_key[127:64];
            r_x4    <= w_r[63:0]   ^ r_key[63:0];
            r_state <= S_AD;
            r_first <= 1'b1;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_AD, S_TEXT: begin
          {r_x0, r_x1, r_x2, r_x3, r_x4} <= w_r;
          r_first <= 1'b0;
          if (w_fin_abs) begin
            r_state <= S_FINAL;
            r_cnt   <= 4'd1;
          end else if (r_cnt == 4'd0) begin
            r_cnt <= 4'd1;
            if (w_ad_abs)
              r_ad_last <= !ADlen[3];
            else
              r_state <= S_TEXT;
          end else if (r_cnt == 4'd5) begin
            r_cnt <= 4'd0;
            if ((r_state == S_AD) && r_ad_last) begin
              r_x4    <= w_r[63:0] ^ 64'd1;
              r_state <= S_TEXT;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_FINAL: begin
          {r_x0, r_x1, r_x2, r_x3, r_x4} <= w_r;
          if (r_cnt == 4'd11) begin
            r_tag   <= w_r[127:0] ^ r_key;
            r_tv    <= 1'b1;
            r_state <= S_DONE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_aead.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_aead
// Purpose  : Self-checking bench for ascon_aead: table of operations checked
//            against a byte-oriented reference sponge, plus restart/reset runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_ascon_aead;

  logic         clk = 1'b0;
  logic         rst, start, startAD, startT, enc;
  logic [127:0] key, nonce;
  logic [63:0]  ADblock, PTblock;
  logic [3:0]   PTlen, ADlen;
  logic [127:0] T;
  logic [63:0]  CTblock;
  logic         CTv, Tv, read;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   m_ad [32];
  logic [7:0]   m_pt [32];
  logic [7:0]   m_ct [32];
  logic [127:0] m_tag;

  typedef struct {
    int           adn;
    int           ptn;
    bit           dec;
    bit           big;
    bit           kat;
    logic [127:0] tag;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  ascon_aead dut (
    .clk(clk), .rst(rst), .start(start), .startAD(startAD), .startT(startT),
    .enc(enc), .key(key), .nonce(nonce), .ADblock(ADblock), .PTblock(PTblock),
    .PTlen(PTlen), .ADlen(ADlen), .T(T), .CTblock(CTblock), .CTv(CTv),
    .Tv(Tv), .read(read)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox5(input logic [4:0] v);
    case (v)
      5'd0:  return 5'd4;   5'd1:  return 5'd11;  5'd2:  return 5'd31;  5'd3:  return 5'd20;
      5'd4:  return 5'd26;  5'd5:  return 5'd21;  5'd6:  return 5'd9;   5'd7:  return 5'd2;
      5'd8:  return 5'd27;  5'd9:  return 5'd5;   5'd10: return 5'd8;   5'd11: return 5'd18;
      5'd12: return 5'd29;  5'd13: return 5'd3;   5'd14: return 5'd6;   5'd15: return 5'd28;
      5'd16: return 5'd30;  5'd17: return 5'd19;  5'd18: return 5'd7;   5'd19: return 5'd14;
      5'd20: return 5'd0;   5'd21: return 5'd13;  5'd22: return 5'd17;  5'd23: return 5'd24;
      5'd24: return 5'd16;  5'd25: return 5'd12;  5'd26: return 5'd1;   5'd27: return 5'd25;
      5'd28: return 5'd22;  5'd29: return 5'd10;  5'd30: return 5'd15;  default: return 5'd23;
    endcase
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int first_r);
    logic [63:0] x [5];
    logic [4:0]  col;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int r = first_r; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = sbox5({x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]});
        x[0][b] = col[4]; x[1][b] = col[3]; x[2][b] = col[2];
        x[3][b] = col[1]; x[4][b] = col[0];
      end
      x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
      x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
      x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
      x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
      x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic model_enc(input logic [127:0] k, input logic [127:0] n, input int adn, input int ptn);
    logic [319:0] s;
    logic [63:0]  blk;
    int           nb, idx;
    s = m_perm({64'h80400c0600000000, k, n}, 0);
    s[127:0] = s[127:0] ^ k;
    if (adn > 0) begin
      nb = adn / 8 + 1;
      for (int i = 0; i < nb; i++) begin
        blk = '0;
        for (int j = 0; j < 8; j++) begin
          idx = 8 * i + j;
          blk[63-8*j -: 8] = (idx < adn) ? m_ad[idx] : ((idx == adn) ? 8'h80 : 8'h00);
        end
        s[319:256] = s[319:256] ^ blk;
        s = m_perm(s, 6);
      end
    end
    s[0] = ~s[0];
    nb = ptn / 8;
    for (int i = 0; i <= nb; i++) begin
      blk = '0;
      for (int j = 0; j < 8; j++) begin
        idx = 8 * i + j;
        blk[63-8*j -: 8] = (idx < ptn) ? m_pt[idx] : ((idx == ptn) ? 8'h80 : 8'h00);
      end
      s[319:256] = s[319:256] ^ blk;
      for (int j = 0; j < 8; j++)
        if (8 * i + j < ptn) m_ct[8*i+j] = s[319-8*j -: 8];
      if (i < nb) s = m_perm(s, 6);
    end
    s[255:128] = s[255:128] ^ k;
    s = m_perm(s, 0);
    m_tag = s[127:0] ^ k;
  endtask

  // ---------------- DUT driving ----------------
  task automatic clear_blocks();
    startAD = 1'b0; startT = 1'b0; ADblock = '0; PTblock = '0; ADlen = '0; PTlen = '0;
  endtask

  task automatic run_op(input int adn, input int ptn, input bit dec, input bit big,
                        input logic [127:0] exp_tag);
    logic [63:0] blk, expv, msk;
    int          nb, rem;
    bit          st;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tv_clear_on_start", 128'(Tv), 128'(0));
    repeat (12) step();
    if (adn > 0) begin
      nb = adn / 8 + 1;
      for (int i = 0; i < nb; i++) begin
        rem = adn - 8 * i;
        blk = '0;
        for (int j = 0; j < 8; j++) if (j < rem) blk[63-8*j -: 8] = m_ad[8*i+j];
        startAD = (i == 0);
        ADblock = blk;
        ADlen   = (rem >= 8) ? (big ? 4'd15 : 4'd8) : 4'(rem);
        #1;
        chk("read_ad", 128'(read), 128'(1));
        chk("ctv_ad", 128'(CTv), 128'(0));
        step();
        clear_blocks();
        chk("read_ad_round", 128'(read), 128'(0));
        repeat (5) step();
      end
    end
    nb = ptn / 8;
    enc = !dec;
    for (int i = 0; i < nb; i++) begin
      blk = '0; expv = '0;
      for (int j = 0; j < 8; j++) begin
        blk[63-8*j -: 8]  = dec ? m_ct[8*i+j] : m_pt[8*i+j];
        expv[63-8*j -: 8] = dec ? m_pt[8*i+j] : m_ct[8*i+j];
      end
      startT = 1'b1; PTlen = big ? 4'd15 : 4'd8; PTblock = blk;
      #1;
      chk("read_text", 128'(read), 128'(1));
      chk("ctv_full", 128'(CTv), 128'(1));
      chk("ct_full", 128'(CTblock), 128'(expv));
      step();
      clear_blocks();
      chk("read_text_round", 128'(read), 128'(0));
      repeat (5) step();
    end
    rem = ptn - 8 * nb;
    st  = !((ptn > 0) && (rem == 0));
    blk = '0; expv = '0; msk = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < rem) begin
        blk[63-8*j -: 8]  = dec ? m_ct[8*nb+j] : m_pt[8*nb+j];
        expv[63-8*j -: 8] = dec ? m_pt[8*nb+j] : m_ct[8*nb+j];
        msk[63-8*j -: 8]  = 8'hff;
      end
    end
    startT = st; PTlen = 4'(rem); PTblock = blk;
    #1;
    chk("read_final", 128'(read), 128'(1));
    chk("ctv_final", 128'(CTv), 128'(st));
    if (st && (rem > 0))
      chk("ct_final", 128'(CTblock & msk), 128'(expv));
    else if (!st)
      chk("ct_zero_no_ctv", 128'(CTblock), 128'(0));
    step();
    clear_blocks();
    repeat (10) step();
    chk("tv_before_last_round", 128'(Tv), 128'(0));
    step();
    chk("tv_after_final", 128'(Tv), 128'(1));
    chk("tag", T, exp_tag);
  endtask

  task automatic fill_data();
    for (int i = 0; i < 32; i++) begin
      m_ad[i] = 8'(i);
      m_pt[i] = 8'(8'h20 + i);
      m_ct[i] = 8'h00;
    end
  endtask

  // Bench sequence: reset checks, vector table, then abort and reset corner cases.
  initial begin
    vecs[0] = '{adn: 0,  ptn: 0,  dec: 1'b0, big: 1'b0, kat: 1'b1,
                tag: 128'he355159f292911f794cb1432a0103a8a};
    vecs[1] = '{adn: 8,  ptn: 3,  dec: 1'b0, big: 1'b0, kat: 1'b0, tag: '0};
    vecs[2] = '{adn: 13, ptn: 21, dec: 1'b0, big: 1'b0, kat: 1'b0, tag: '0};
    vecs[3] = '{adn: 0,  ptn: 16, dec: 1'b0, big: 1'b0, kat: 1'b0, tag: '0};
    vecs[4] = '{adn: 13, ptn: 21, dec: 1'b1, big: 1'b0, kat: 1'b0, tag: '0};
    vecs[5] = '{adn: 9,  ptn: 8,  dec: 1'b0, big: 1'b1, kat: 1'b0, tag: '0};

    rst = 1'b1; start = 1'b0; enc = 1'b1;
    clear_blocks();
    key   = 128'h000102030405060708090a0b0c0d0e0f;
    nonce = 128'h000102030405060708090a0b0c0d0e0f;
    repeat (3) step();
    rst = 1'b0;
    startT = 1'b1; PTblock = 64'hffff_ffff_ffff_ffff; PTlen = 4'd8;
    #1;
    chk("reset_T", T, 128'(0));
    chk("reset_Tv", 128'(Tv), 128'(0));
    chk("reset_CTv", 128'(CTv), 128'(0));
    chk("reset_CTblock", 128'(CTblock), 128'(0));
    chk("reset_read", 128'(read), 128'(0));
    clear_blocks();
    step();

    for (int v = 0; v < 6; v++) begin
      fill_data();
      model_enc(key, nonce, vecs[v].adn, vecs[v].ptn);
      run_op(vecs[v].adn, vecs[v].ptn, vecs[v].dec, vecs[v].big,
             vecs[v].kat ? vecs[v].tag : m_tag);
    end

    repeat (3) step();
    chk("tv_held_done", 128'(Tv), 128'(1));
    chk("tag_held_done", T, m_tag);

    // Restart in the middle of text rounds, then a clean empty-message run.
    start = 1'b1; step(); start = 1'b0;
    repeat (12) step();
    enc = 1'b1; startT = 1'b1; PTlen = 4'd8; PTblock = 64'h0123_4567_89ab_cdef;
    step();
    clear_blocks();
    repeat (2) step();
    run_op(0, 0, 1'b0, 1'b0, 128'he355159f292911f794cb1432a0103a8a);

    // Reset in the middle of associated-data rounds.
    fill_data();
    start = 1'b1; step(); start = 1'b0;
    repeat (12) step();
    startAD = 1'b1; ADblock = 64'h0001_0203_0405_0607; ADlen = 4'd8;
    step();
    clear_blocks();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_Tv", 128'(Tv), 128'(0));
    chk("rst_mid_T", T, 128'(0));
    chk("rst_mid_read", 128'(read), 128'(0));
    model_enc(key, nonce, 13, 21);
    run_op(13, 21, 1'b0, 1'b0, m_tag);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
`default_nettype wire
